convnet: RTL and testbench
==========================

Name: convnet

Overview:
- Single-channel 3x3 convolution engine between an FX2-style USB slave FIFO and a Wishbone SDRAM controller.
- Per job it:
  - reads nine 16-bit kernel words and nine 16-bit patch words from USB endpoint EP2;
  - computes their dot product;
  - stores the 32-bit result to SDRAM and reads it back;
  - returns it to the host on EP6 as two 16-bit words followed by a packet-end strobe.

Parameters:
- TAPS, 9, kernel/patch words per job.
- RES_DEPTH, 120, SDRAM result slots; the slot index wraps at this value.
- FIFO_RD_ADR, 2'b00, FIFOADR value for EP2 reads.
- FIFO_WR_ADR, 2'b10, FIFOADR value for EP6 writes.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-high despite the name.
- FLAGA  in  1  1 = EP2 holds data.
- FLAGD  in  1  1 = EP6 has room.
- FDATA  inout  16  FIFO data bus; driven only in the EP6 write and pktend states, otherwise high-Z.
- FIFOADR  out  2  endpoint select.
- SLRD  out  1  FIFO read strobe, active-low.
- SLWR  out  1  FIFO write strobe, active-low.
- SLOE  out  1  FIFO output enable, active-low.
- pktend  out  1  packet end, active-low.
- IFCLK  out  1  CLK forwarded unchanged to the FIFO.
- LED  out  4  equals cstate.
- cstate  out  4  current FSM state code (debug).
- KERNELS_d  out  144  {k8..k0}, k0 in [15:0] (debug).
- PATCHES_d  out  144  {p8..p0}, p0 in [15:0] (debug).
- data_o  in  32  Wishbone read data.
- stall_o  in  1  Wishbone stall.
- sdram_ack  in  1  Wishbone ack.
- stb_i  out  1  Wishbone strobe.
- we_i  out  1  Wishbone write enable.
- sel_i  out  4  byte select, constant 4'hF.
- cyc_i  out  1  Wishbone cycle.
- addr_i  out  32  word address = result slot index (0..119).
- data_i  out  32  Wishbone write data.

Behaviour:
- Reset values:
  - SLRD = SLWR = SLOE = pktend = 1; FIFOADR = 00; FDATA high-Z.
  - cyc_i = stb_i = we_i = 0; addr_i = data_i = 0.
  - Kernel, patch, accumulator and read-back registers = 0; tap counter = 0; slot index = 0; cstate = 0 (IDLE).
  - Reset mid-operation drops cyc_i/stb_i and all strobes on the next edge.
- States (cstate code):
  - 0 IDLE: go to RD_K when FLAGA = 1.
  - 1 RD_K: FIFOADR = 00, SLOE = 0, SLRD = FLAGA ? 0 : 1.
    - On each edge with SLRD = 0 and FLAGA = 1, capture FDATA into k[cnt] and increment cnt.
    - After the 9th word: cnt = 0, go to RD_P.
    - FLAGA low: pause with SLRD = 1, keep cnt.
  - 2 RD_P: identical to RD_K, filling p[0..8], then go to MAC.
  - 3 MAC: clear acc on entry; one tap per cycle, acc += k[i]*p[i], unsigned 16x16 products, 36-bit accumulator; 9 cycles, then go to WB_WR.
  - 4 WB_WR: wait until sdram_ack = 0, then assert cyc_i = stb_i = we_i = 1, addr_i = slot, data_i = acc[31:0].
    - Hold all bus outputs stable until sdram_ack = 1.
    - Drop cyc_i/stb_i/we_i on the edge after ack is sampled, then go to WB_RD.
  - 5 WB_RD: same handshake with we_i = 0 (again waiting for ack low first); latch data_o into rb on the ack cycle; go to US_L.
  - 6 US_L: FIFOADR = 10. While FLAGD = 0, wait with SLWR = 1. When FLAGD = 1, drive FDATA = rb[15:0] with SLWR = 0 for exactly one cycle, then go to US_H.
  - 7 US_H: same as US_L with rb[31:16], then go to PEND.
  - 8 PEND: pktend = 0 for one cycle with FIFOADR = 10; slot = (slot == 119) ? 0 : slot + 1; go to IDLE.
- stall_o = 1 extends stb_i hold; the transaction completes only on ack.
- No strobe (SLRD, SLWR, pktend) is ever asserted simultaneously with another; SLOE = 0 only in RD_K/RD_P.

Decomposition:
- Shared package convnet_pkg: state encodings (4-bit), TAPS, RES_DEPTH, FIFOADR constants.
- One natural sub-module: wb_master (single-transaction Wishbone handshake: start, we, addr, wdata in; done, rdata out). The FSM and MAC stay in the top.

Test Plan:
- Reset held 5 cycles -> SLRD/SLWR/SLOE/pktend = 1, cyc_i = 0, cstate = 0, FDATA high-Z.
- EP2 model supplies an incrementing counter (0..17) after FLAGA rises -> KERNELS_d words 0..8, PATCHES_d words 9..17, exactly 18 SLRD-low cycles.
- Same job with a slave that acks 5 cycles after stb (ack held until cyc drops) -> single write to addr 0 with data_i = 0x00000210 (528), then a read of addr 0 returning 0x210.
- With FLAGD = 1 -> EP6 receives 0x0210 then 0x0000 on FIFOADR = 10, followed by one pktend-low cycle, return to IDLE.
- FLAGA deasserted 3 cycles mid-kernel, and FLAGD held 0 for 10 cycles before the US_L write -> no word lost or duplicated; SLWR stays high until FLAGD = 1.
- Run 121 jobs -> slot index wraps so that job 121 writes addr 0; reset asserted during WB_WR drops cyc_i on the next edge.

Source files
------------

// File: rtl/convnet_pkg.sv
// Shared constants and FSM state encodings for the convnet 3x3 convolution engine.
package convnet_pkg;
  localparam int TAPS      = 9;
  localparam int RES_DEPTH = 120;
  localparam int CNT_W     = 4;
  localparam int SLOT_W    = 7;

  localparam logic [1:0] FIFO_RD_ADR = 2'b00;
  localparam logic [1:0] FIFO_WR_ADR = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RD_K  = 4'd1,
    ST_RD_P  = 4'd2,
    ST_MAC   = 4'd3,
    ST_WB_WR = 4'd4,
    ST_WB_RD = 4'd5,
    ST_US_L  = 4'd6,
    ST_US_H  = 4'd7,
    ST_PEND  = 4'd8
  } state_t;
endpackage

// File: rtl/convnet_wb_master.sv
// Single-transaction Wishbone master: launches on i_start once ack is low, holds the
// bus until ack, then pulses o_done for one cycle with read data captured.
module convnet_wb_master (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_ack,
  input  logic        i_stall,
  input  logic [31:0] i_rdat,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata
);
  logic        r_cyc;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_done;
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_cyc) begin
        if (i_ack) begin
          r_cyc   <= 1'b0;
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_rdata <= i_rdat;
        end
      end else if (i_start && !r_done && !i_ack && !i_stall) begin
        // a stale ack from the previous cycle must clear before a new request starts
        r_cyc   <= 1'b1;
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end
  end

  assign o_cyc   = r_cyc;
  assign o_stb   = r_cyc;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_done  = r_done;
  assign o_rdata = r_rdata;
endmodule

// File: rtl/convnet.sv
// 3x3 dot-product engine: kernel/patch from USB EP2, result written to SDRAM,
// read back, and returned on EP6 as low word, high word, packet end.
module convnet
  import convnet_pkg::*;
(
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          FLAGA,
  input  logic          FLAGD,
  inout  wire  [15:0]   FDATA,
  output logic [1:0]    FIFOADR,
  output logic          SLRD,
  output logic          SLWR,
  output logic          SLOE,
  output logic          pktend,
  output logic          IFCLK,
  output logic [3:0]    LED,
  output logic [3:0]    cstate,
  output logic [143:0]  KERNELS_d,
  output logic [143:0]  PATCHES_d,
  input  logic [31:0]   data_o,
  input  logic          stall_o,
  input  logic          sdram_ack,
  output logic          stb_i,
  output logic          we_i,
  output logic [3:0]    sel_i,
  output logic          cyc_i,
  output logic [31:0]   addr_i,
  output logic [31:0]   data_i
);
  state_t                r_state, w_next;
  logic [TAPS-1:0][15:0] r_k, r_p;
  logic [CNT_W-1:0]      r_cnt;
  logic [35:0]           r_acc;
  logic [31:0]           r_rb;
  logic [SLOT_W-1:0]     r_slot;

  logic        w_last;
  logic [31:0] w_prod;
  logic        w_fd_oe;
  logic [15:0] w_fd_out;
  logic        w_wb_start;
  logic        w_wb_we;
  logic        w_wb_done;
  logic [31:0] w_wb_rdata;

  assign w_last = (r_cnt == CNT_W'(TAPS - 1));
  assign w_prod = {16'b0, r_k[r_cnt]} * {16'b0, r_p[r_cnt]};

  always_ff @(posedge CLK) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    FIFOADR    = FIFO_RD_ADR;
    SLRD       = 1'b1;
    SLWR       = 1'b1;
    SLOE       = 1'b1;
    pktend     = 1'b1;
    w_fd_oe    = 1'b0;
    w_fd_out   = 16'h0;
    w_wb_start = 1'b0;
    w_wb_we    = 1'b0;
    case (r_state)
      ST_IDLE: if (FLAGA) w_next = ST_RD_K;
      ST_RD_K, ST_RD_P: begin
        SLOE = 1'b0;
        SLRD = ~FLAGA;
        if (FLAGA && w_last) w_next = (r_state == ST_RD_K) ? ST_RD_P : ST_MAC;
      end
      ST_MAC: if (w_last) w_next = ST_WB_WR;
      ST_WB_WR: begin
        w_wb_start = 1'b1;
        w_wb_we    = 1'b1;
        if (w_wb_done) w_next = ST_WB_RD;
      end
      ST_WB_RD: begin
        w_wb_start = 1'b1;
        if (w_wb_done) w_next = ST_US_L;
      end
      ST_US_L, ST_US_H: begin
        FIFOADR  = FIFO_WR_ADR;
        w_fd_oe  = 1'b1;
        w_fd_out = (r_state == ST_US_L) ? r_rb[15:0] : r_rb[31:16];
        SLWR     = ~FLAGD;
        if (FLAGD) w_next = (r_state == ST_US_L) ? ST_US_H : ST_PEND;
      end
      ST_PEND: begin
        FIFOADR = FIFO_WR_ADR;
        w_fd_oe = 1'b1;
        pktend  = 1'b0;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst_n) begin
      r_k    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_rb   <= '0;
      r_slot <= '0;
    end else begin
      case (r_state)
        ST_RD_K: if (FLAGA) begin
          r_k[r_cnt] <= FDATA;
          r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
        end
        ST_RD_P: if (FLAGA) begin
          r_p[r_cnt] <= FDATA;
          r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) r_acc <= '0;
        end
        ST_MAC: begin
          r_acc <= r_acc + {4'b0, w_prod};
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        ST_WB_RD: if (w_wb_done) r_rb <= w_wb_rdata;
        ST_PEND:  r_slot <= (r_slot == SLOT_W'(RES_DEPTH - 1)) ? '0 : r_slot + 1'b1;
        default: ;
      endcase
    end
  end

  convnet_wb_master u_wb (
    .i_clk   (CLK),
    .i_rst   (rst_n),
    .i_start (w_wb_start),
    .i_we    (w_wb_we),
    .i_addr  ({{(32-SLOT_W){1'b0}}, r_slot}),
    .i_wdata (r_acc[31:0]),
    .i_ack   (sdram_ack),
    .i_stall (stall_o),
    .i_rdat  (data_o),
    .o_cyc   (cyc_i),
    .o_stb   (stb_i),
    .o_we    (we_i),
    .o_addr  (addr_i),
    .o_wdata (data_i),
    .o_done  (w_wb_done),
    .o_rdata (w_wb_rdata)
  );

  assign FDATA     = w_fd_oe ? w_fd_out : 16'bz;
  assign sel_i     = 4'hF;
  assign IFCLK     = CLK;
  assign cstate    = r_state;
  assign LED       = r_state;
  assign KERNELS_d = r_k;
  assign PATCHES_d = r_p;
endmodule

// File: tb/tb_convnet.sv
// Scoreboard bench for convnet: EP2 counter source, delayed-ack Wishbone slave,
// and a negedge monitor checking bus transactions and EP6 traffic against queued expectations.
module tb_convnet;
  logic         CLK = 1'b0;
  logic         rst_n = 1'b1;
  logic         FLAGA = 1'b0;
  logic         FLAGD = 1'b0;
  wire  [15:0]  FDATA;
  logic [1:0]   FIFOADR;
  logic         SLRD, SLWR, SLOE, pktend, IFCLK;
  logic [3:0]   LED, cstate;
  logic [143:0] KERNELS_d, PATCHES_d;
  logic [31:0]  data_o;
  logic         stall_o = 1'b0;
  logic         sdram_ack = 1'b0;
  logic         stb_i, we_i, cyc_i;
  logic [3:0]   sel_i;
  logic [31:0]  addr_i, data_i;

  always #5 CLK = ~CLK;

  convnet dut (
    .CLK(CLK), .rst_n(rst_n), .FLAGA(FLAGA), .FLAGD(FLAGD), .FDATA(FDATA),
    .FIFOADR(FIFOADR), .SLRD(SLRD), .SLWR(SLWR), .SLOE(SLOE), .pktend(pktend),
    .IFCLK(IFCLK), .LED(LED), .cstate(cstate), .KERNELS_d(KERNELS_d),
    .PATCHES_d(PATCHES_d), .data_o(data_o), .stall_o(stall_o),
    .sdram_ack(sdram_ack), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i),
    .cyc_i(cyc_i), .addr_i(addr_i), .data_i(data_i)
  );

  // EP2 source: incrementing word counter, advanced on each accepted read
  logic [15:0] ep2_word = 16'h0;
  int          words_rd = 0;
  assign FDATA = (SLOE == 1'b0) ? ep2_word : 16'hzzzz;
  always @(posedge CLK)
    if (SLRD == 1'b0 && FLAGA) begin
      ep2_word <= ep2_word + 16'd1;
      words_rd <= words_rd + 1;
    end

  // Wishbone slave: ack 5 cycles after stb, held until cyc drops
  logic [31:0] mem [0:127];
  int          ack_cnt = 0;
  assign data_o = mem[addr_i[6:0]];
  always @(posedge CLK) begin
    if (!cyc_i) begin
      sdram_ack <= 1'b0;
      ack_cnt   <= 0;
    end else if (stb_i && !sdram_ack) begin
      if (ack_cnt == 4) begin
        sdram_ack <= 1'b1;
        if (we_i) mem[addr_i[6:0]] <= data_i;
      end else ack_cnt <= ack_cnt + 1;
    end
  end

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_t;

  wb_t         q_wb[$];
  logic [16:0] q_ep[$];
  int          total = 0;
  int          bad = 0;
  int          srd_cnt = 0;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin : mon
    wb_t         e;
    logic [16:0] x;
    int          n;
    if (!rst_n) begin
      n = 0;
      if (!SLRD) begin n++; srd_cnt++; chk("ep2_ctl", 144'({SLOE, FIFOADR}), 144'(3'b000)); end
      if (!SLWR) n++;
      if (!pktend) n++;
      if (n > 0) chk("strobe_excl", 144'(n), 144'(1));
      if (!SLOE) chk("sloe_state", 144'(cstate == 4'd1 || cstate == 4'd2), 144'(1));
      if (cyc_i && stb_i && sdram_ack) begin
        if (q_wb.size() == 0) chk("wb_unexpected", 144'(1), 144'(0));
        else begin
          e = q_wb.pop_front();
          chk("wb_txn", 144'({we_i, sel_i, addr_i, (we_i ? data_i : 32'h0)}),
                        144'({e.we, 4'hF, e.adr, (e.we ? e.dat : 32'h0)}));
        end
      end
      if (!SLWR) begin
        chk("ep6_room", 144'(FLAGD), 144'(1));
        if (q_ep.size() == 0) chk("ep6_unexpected", 144'(1), 144'(0));
        else begin
          x = q_ep.pop_front();
          chk("ep6_word", 144'({FIFOADR, 1'b0, FDATA}), 144'({2'b10, x}));
        end
      end
      if (!pktend) begin
        if (q_ep.size() == 0) chk("pktend_unexpected", 144'(1), 144'(0));
        else begin
          x = q_ep.pop_front();
          chk("pktend", 144'({FIFOADR, 1'b1}), 144'({2'b10, x[16]}));
        end
      end
    end
  end

  task automatic wait_cs(input logic [3:0] s, input int budget, input string nm);
    int n = 0;
    while (cstate !== s && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, 144'(cstate), 144'(s));
  endtask

  task automatic feed_ep2(input bit pause);
    int  rd0 = words_rd;
    int  n = 0;
    bit  paused = 0;
    FLAGA = 1'b1;
    while (words_rd - rd0 < 18 && n < 400) begin
      @(negedge CLK);
      n++;
      if (pause && !paused && words_rd - rd0 == 4) begin
        paused = 1;
        FLAGA  = 1'b0;
        repeat (3) @(negedge CLK);
        FLAGA  = 1'b1;
      end
    end
    FLAGA = 1'b0;
    chk("ep2_words", 144'(words_rd - rd0), 144'(18));
  endtask

  function automatic logic [31:0] dot(input logic [15:0] b);
    logic [35:0] a = '0;
    for (int i = 0; i < 9; i++) a += 36'(b + 16'(i)) * 36'(b + 16'(i + 9));
    return a[31:0];
  endfunction

  task automatic run_job(input logic [31:0] res, input logic [6:0] slot, input bit pause, input int dly);
    logic [15:0]  b = ep2_word;
    logic [143:0] ek, ep;
    wb_t          e;
    int           s0 = srd_cnt;
    for (int i = 0; i < 9; i++) begin
      ek[i*16 +: 16] = b + 16'(i);
      ep[i*16 +: 16] = b + 16'(i + 9);
    end
    e = {1'b1, 32'(slot), res}; q_wb.push_back(e);
    e = {1'b0, 32'(slot), res}; q_wb.push_back(e);
    q_ep.push_back({1'b0, res[15:0]});
    q_ep.push_back({1'b0, res[31:16]});
    q_ep.push_back({1'b1, 16'h0});
    FLAGD = (dly == 0);
    feed_ep2(pause);
    if (dly > 0) begin
      wait_cs(4'd6, 300, "reach_us_l");
      repeat (dly) @(negedge CLK);
      chk("slwr_hold", 144'({cstate, SLWR}), 144'({4'd6, 1'b1}));
      FLAGD = 1'b1;
    end
    wait_cs(4'd8, 300, "reach_pend");
    wait_cs(4'd0, 4, "back_idle");
    chk("kernels", KERNELS_d, ek);
    chk("patches", PATCHES_d, ep);
    chk("slrd_cycles", 144'(srd_cnt - s0), 144'(18));
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    repeat (5) @(negedge CLK);
    chk("rst_strobes", 144'({SLRD, SLWR, SLOE, pktend, FIFOADR}), 144'(6'b111100));
    chk("rst_bus", 144'({cyc_i, stb_i, we_i, addr_i, data_i}), 144'(0));
    chk("rst_state", 144'(cstate), 144'(0));
    chk("rst_fdata_z", 144'(FDATA === 16'hzzzz), 144'(1));
    chk("rst_regs", 144'({KERNELS_d, PATCHES_d} == '0), 144'(1));
    rst_n = 1'b0;
    @(negedge CLK);

    run_job(32'h0000_0210, 7'd0, 1'b0, 0);
    run_job(32'h0000_1836, 7'd1, 1'b1, 10);
    for (int j = 2; j < 120; j++) run_job(dot(ep2_word), 7'(j), 1'b0, 0);
    run_job(dot(ep2_word), 7'd0, 1'b0, 0);

    // reset while the write transaction is in flight
    FLAGD = 1'b1;
    feed_ep2(1'b0);
    wait_cs(4'd4, 50, "reach_wb_wr");
    n = 0;
    while (!cyc_i && n < 20) begin @(negedge CLK); n++; end
    chk("wb_wr_cyc", 144'(cyc_i), 144'(1));
    rst_n = 1'b1;
    @(negedge CLK);
    chk("rst_mid_bus", 144'({cyc_i, stb_i, we_i}), 144'(0));
    chk("rst_mid_state", 144'({cstate, SLRD, SLWR, pktend}), 144'({4'd0, 3'b111}));
    chk("rst_mid_regs", 144'(KERNELS_d == '0), 144'(1));
    rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    chk("sb_empty", 144'(q_wb.size() + q_ep.size()), 144'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
